if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V core.
- Each cycle it selects the next fetch address: the sequential PC or a branch/jump target.
- It registers that address as the instruction-memory address and provides PC+4 for the sequential path and the IF/ID register.
- The PC loop is closed externally: the parent feeds `pc4` back into `pc` when not branching.

---
 rtl/if_pkg.sv | 10 +
 rtl/if_stage_if.sv | 38 +++
 rtl/if_stage_pc_reg.sv | 21 ++
 rtl/if_stage.sv | 52 +++++
 tb/tb_if_stage.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          PC_INC   = 4;

  typedef logic [XLEN-1:0] addr_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus between the core and if_stage.
// The inst_misaligned signal exists only when IF_MISALIGN_CHK_EN is defined.
interface if_stage_if #(
  parameter int XLEN = if_pkg::XLEN
) ();

  logic            pc_src;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] branch_addr;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] inst_addr;
`ifdef IF_MISALIGN_CHK_EN
  logic            inst_misaligned;
`endif

  modport master (
    output pc_src,
    output pc,
    output branch_addr,
    input  pc4,
`ifdef IF_MISALIGN_CHK_EN
    input  inst_misaligned,
`endif
    input  inst_addr
  );

  modport slave (
    input  pc_src,
    input  pc,
    input  branch_addr,
    output pc4,
`ifdef IF_MISALIGN_CHK_EN
    output inst_misaligned,
`endif
    output inst_addr
  );

endinterface

// File: rtl/if_stage_pc_reg.sv
// Program-counter register: loads every cycle, async active-low reset to RESET_PC.
module pc_reg #(
  parameter int              XLEN     = if_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(if_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  logic [XLEN-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RESET_PC;
    else        q_q <= d;
  end

  assign q = q_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC mux, PC register and PC+4 adder.
// Define IF_MISALIGN_CHK_EN to add the registered inst_misaligned flag.
module if_stage #(
  parameter int              XLEN     = if_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(if_pkg::RESET_PC)
) (
  input  logic     clk,
  input  logic     reset,
  if_stage_if.slave bus
);

  import if_pkg::*;

  logic [XLEN-1:0] next_pc_d;
  logic [XLEN-1:0] inst_addr;

  // A taken branch/jump overrides the sequential candidate.
  always_comb begin
    next_pc_d = bus.pc;
    if (bus.pc_src) next_pc_d = bus.branch_addr;
  end

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (reset),
    .d     (next_pc_d),
    .q     (inst_addr)
  );

  assign bus.inst_addr = inst_addr;
  assign bus.pc4       = inst_addr + XLEN'(PC_INC);

`ifdef IF_MISALIGN_CHK_EN
  logic misaligned_d;
  logic misaligned_q;

  always_comb begin
    misaligned_d = (next_pc_d[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misaligned_q <= 1'b0;
    else        misaligned_q <= misaligned_d;
  end

  assign bus.inst_misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage against a behavioural next-PC model.
module tb_if_stage;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [31:0] exp_addr;
  logic        exp_mis;

  if_stage_if #(.XLEN(32)) bus ();

  if_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; the model loads the selected address when reset is high.
  task automatic tick();
    logic [31:0] nxt;
    nxt = bus.pc_src ? bus.branch_addr : bus.pc;
    @(posedge clk);
    if (reset) begin
      exp_addr = nxt;
      exp_mis  = (nxt % 4) != 0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_addr = 32'h0;
    exp_mis  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.pc_src = 1'b0;
    bus.pc = $urandom;
    bus.branch_addr = $urandom;
    exp_addr = 32'h0;
    exp_mis  = 1'b0;
    #2;
    checks++;
    if (bus.inst_addr !== 32'h0) begin
      failures++; $display("FAIL reset_addr got=%h exp=%h", bus.inst_addr, 32'h0);
    end
    checks++;
    if (bus.pc4 !== 32'h4) begin
      failures++; $display("FAIL reset_pc4 got=%h exp=%h", bus.pc4, 32'h4);
    end
    for (int i = 0; i < 3; i++) begin
      bus.pc_src = i[0];
      bus.pc = $urandom;
      bus.branch_addr = $urandom;
      tick();
      checks++;
      if (bus.inst_addr !== 32'h0 || bus.pc4 !== 32'h4) begin
        failures++;
        $display("FAIL reset_hold got=%h/%h exp=%h/%h", bus.inst_addr, bus.pc4, 32'h0, 32'h4);
      end
    end
`ifdef IF_MISALIGN_CHK_EN
    checks++;
    if (bus.inst_misaligned !== 1'b0) begin
      failures++; $display("FAIL reset_mis got=%b exp=0", bus.inst_misaligned);
    end
`endif
  endtask

  task automatic test_sequential();
    do_reset();
    bus.pc_src = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.inst_addr !== 32'(4 * i) || bus.pc4 !== 32'(4 * i + 4)) begin
        failures++;
        $display("FAIL seq[%0d] got=%h/%h exp=%h/%h", i, bus.inst_addr, bus.pc4, 32'(4 * i), 32'(4 * i + 4));
      end
      bus.pc = 32'(4 * i + 4);
      bus.branch_addr = $urandom;
      tick();
    end
  endtask

  task automatic test_branch();
    do_reset();
    bus.pc_src = 1'b0;
    bus.pc = 32'h4; tick();
    bus.pc = 32'h8; tick();
    checks++;
    if (bus.inst_addr !== 32'h8) begin
      failures++; $display("FAIL branch_pre got=%h exp=%h", bus.inst_addr, 32'h8);
    end
    bus.pc_src = 1'b1;
    bus.branch_addr = 32'h100;
    bus.pc = 32'hC;
    tick();
    checks++;
    if (bus.inst_addr !== 32'h100 || bus.pc4 !== 32'h104) begin
      failures++; $display("FAIL branch_take got=%h/%h exp=100/104", bus.inst_addr, bus.pc4);
    end
    bus.pc_src = 1'b0;
    bus.pc = 32'h104;
    bus.branch_addr = 32'h200;
    tick();
    checks++;
    if (bus.inst_addr !== 32'h104) begin
      failures++; $display("FAIL branch_after got=%h exp=%h", bus.inst_addr, 32'h104);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] ld;
    do_reset();
    bus.pc_src = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus.pc = 32'(4 * i);
      tick();
    end
    checks++;
    if (bus.inst_addr !== 32'h20) begin
      failures++; $display("FAIL midrst_pre got=%h exp=%h", bus.inst_addr, 32'h20);
    end
    #2;
    reset = 1'b0;
    exp_addr = 32'h0;
    #1;
    checks++;
    if (bus.inst_addr !== 32'h0 || bus.pc4 !== 32'h4) begin
      failures++; $display("FAIL midrst_async got=%h/%h exp=0/4", bus.inst_addr, bus.pc4);
    end
    bus.pc = 32'h24;
    tick();
    checks++;
    if (bus.inst_addr !== 32'h0) begin
      failures++; $display("FAIL midrst_hold got=%h exp=%h", bus.inst_addr, 32'h0);
    end
    reset = 1'b1;
    ld = $urandom & 32'hFFFF_FFFC;
    bus.pc = ld;
    tick();
    checks++;
    if (bus.inst_addr !== ld) begin
      failures++; $display("FAIL midrst_release got=%h exp=%h", bus.inst_addr, ld);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.pc_src = 1'b0;
    bus.pc = 32'hFFFF_FFFC;
    tick();
    checks++;
    if (bus.inst_addr !== 32'hFFFF_FFFC || bus.pc4 !== 32'h0) begin
      failures++; $display("FAIL wrap_pc4 got=%h/%h exp=fffffffc/0", bus.inst_addr, bus.pc4);
    end
    bus.pc = 32'h0;
    tick();
    checks++;
    if (bus.inst_addr !== 32'h0 || bus.pc4 !== 32'h4) begin
      failures++; $display("FAIL wrap_next got=%h/%h exp=0/4", bus.inst_addr, bus.pc4);
    end
  endtask

`ifdef IF_MISALIGN_CHK_EN
  task automatic test_misaligned();
    do_reset();
    bus.pc_src = 1'b1;
    bus.branch_addr = 32'h102;
    bus.pc = 32'h4;
    tick();
    checks++;
    if (bus.inst_addr !== 32'h102 || bus.inst_misaligned !== 1'b1) begin
      failures++; $display("FAIL mis_set got=%h/%b exp=102/1", bus.inst_addr, bus.inst_misaligned);
    end
    bus.pc_src = 1'b0;
    bus.pc = 32'h108;
    tick();
    checks++;
    if (bus.inst_addr !== 32'h108 || bus.inst_misaligned !== 1'b0) begin
      failures++; $display("FAIL mis_clear got=%h/%b exp=108/0", bus.inst_addr, bus.inst_misaligned);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      bus.pc_src = ($urandom_range(0, 3) == 0);
      bus.pc = ($urandom_range(0, 1) == 0) ? exp_addr + 32'd4 : $urandom;
      bus.branch_addr = $urandom;
      if ($urandom_range(0, 31) == 0) begin
        reset = 1'b0;
        exp_addr = 32'h0;
        exp_mis  = 1'b0;
      end else begin
        reset = 1'b1;
      end
      tick();
      checks++;
      if (bus.inst_addr !== exp_addr || bus.pc4 !== exp_addr + 32'd4) begin
        failures++;
        $display("FAIL rand[%0d] got=%h/%h exp=%h/%h", i, bus.inst_addr, bus.pc4, exp_addr, exp_addr + 32'd4);
      end
`ifdef IF_MISALIGN_CHK_EN
      checks++;
      if (bus.inst_misaligned !== exp_mis) begin
        failures++; $display("FAIL rand_mis[%0d] got=%b exp=%b", i, bus.inst_misaligned, exp_mis);
      end
`endif
    end
    reset = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.pc_src = 1'b0;
    bus.pc = 32'h0;
    bus.branch_addr = 32'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_mid_reset();
    test_wrap();
`ifdef IF_MISALIGN_CHK_EN
    test_misaligned();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
